fetch_stage: RTL and testbench

//  Instruction fetch stage plus IF/ID pipeline register. Holds the PC and drives a synchronous
//  (1-cycle read latency) instruction memory. Delivers instr_o/pc_o/pcplus4_o/valid_o to decode,

---
 rtl/fetch_stage.sv | 54 +++++
 tb/tb_fetch_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing over a 1-cycle imem, with a stall skid buffer and the IF/ID register
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pcplus4_o,
   output logic        valid_o
);
   logic [31:0] fetch_pc_q, inflight_pc_q, skid_q;
   logic        inflight_vld_q, skid_vld_q;
   assign imem_addr_o = fetch_pc_q;
   // redirect beats stall; a stall parks the returning word in the skid so it is issued exactly once
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         fetch_pc_q     <= RESET_PC;
         inflight_pc_q  <= RESET_PC;
         inflight_vld_q <= 1'b0;
         skid_q         <= '0;
         skid_vld_q     <= 1'b0;
         instr_o        <= NOP_INSTR;
         pc_o           <= '0;
         pcplus4_o      <= '0;
         valid_o        <= 1'b0;
      end else if (redirect_i) begin
         fetch_pc_q     <= {redirect_pc_i[31:2], 2'b00};
         inflight_vld_q <= 1'b0;
         skid_vld_q     <= 1'b0;
         instr_o        <= NOP_INSTR;
         valid_o        <= 1'b0;
      end else if (stall_i) begin
         if (!skid_vld_q) begin
            skid_q     <= imem_rdata_i;
            skid_vld_q <= 1'b1;
         end
      end else begin
         instr_o        <= !inflight_vld_q ? NOP_INSTR : skid_vld_q ? skid_q : imem_rdata_i;
         pc_o           <= inflight_pc_q;
         pcplus4_o      <= inflight_pc_q + 32'd4;
         valid_o        <= inflight_vld_q;
         inflight_pc_q  <= fetch_pc_q;
         inflight_vld_q <= 1'b1;
         fetch_pc_q     <= fetch_pc_q + 32'd4;
         skid_vld_q     <= 1'b0;
      end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random stall/redirect traffic checked against an instruction-stream model
module tb_fetch_stage;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;
   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redir = 1'b0;
   logic [31:0] redir_pc = '0, imem_addr, imem_rdata = '0, instr, pc, pcplus4;
   logic        valid;
   int          passed = 0, total = 0;
   logic [31:0] m_pc, m_next;
   logic        m_vld;
   int          m_bub;
   fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redir), .redirect_pc_i(redir_pc),
      .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata), .instr_o(instr), .pc_o(pc),
      .pcplus4_o(pcplus4), .valid_o(valid)
   );
   always #5 clk = ~clk;
   always @(posedge clk) imem_rdata <= imem_addr ^ KEY;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      else passed++;
   endtask
   // model: stream of delivered PCs, with a count of bubble cycles still owed before the next real one
   task automatic model_reset();
      m_vld = 1'b0;
      m_pc = '0;
      m_next = RESET_PC;
      m_bub = 1;
   endtask
   task automatic step(input logic s, input logic r, input logic [31:0] t);
      stall = s;
      redir = r;
      redir_pc = t;
      @(posedge clk);
      if (r) begin
         m_vld = 1'b0;
         m_next = t & ~32'd3;
         m_bub = 1;
      end else if (!s) begin
         if (m_bub > 0) begin
            m_bub--;
            m_vld = 1'b0;
         end else begin
            m_vld = 1'b1;
            m_pc = m_next;
            m_next = m_next + 32'd4;
         end
      end
      @(negedge clk);
      chk("valid", {31'd0, valid}, {31'd0, m_vld});
      if (m_vld) begin
         chk("pc", pc, m_pc);
         chk("pcplus4", pcplus4, m_pc + 32'd4);
         chk("instr", instr, m_pc ^ KEY);
      end else chk("bubble_instr", instr, NOP);
   endtask
   task automatic check_reset_vals();
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_instr", instr, NOP);
      chk("rst_pc", pc, 32'd0);
      chk("rst_pcplus4", pcplus4, 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      check_reset_vals();
      rst = 1'b0;
      model_reset();
      // plain fetch from reset
      step(0, 0, 0);
      chk("t1_fill", {31'd0, valid}, 32'd0);
      step(0, 0, 0);
      chk("t1_first_pc", pc, 32'd0);
      step(0, 0, 0);
      chk("t1_second_pc", pc, 32'd4);
      step(0, 0, 0);
      chk("t1_third_pc", pc, 32'd8);
      // stall held at pc 8, then release
      repeat (3) step(1, 0, 0);
      chk("t2_hold_pc", pc, 32'd8);
      step(0, 0, 0);
      chk("t2_after_pc", pc, 32'd12);
      step(0, 0, 0);
      chk("t2_after2_pc", pc, 32'd16);
      // redirect to 0x100
      step(0, 1, 32'h100);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("t3_target", pc, 32'h100);
      step(0, 0, 0);
      chk("t3_target4", pc, 32'h104);
      // redirect together with stall, then redirect while stalled
      step(1, 1, 32'h200);
      step(1, 0, 0);
      step(1, 1, 32'h300);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("t4_target", pc, 32'h300);
      // misaligned target and wrap-around
      step(0, 1, 32'h103);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("t5_align", pc, 32'h100);
      step(0, 1, 32'hFFFF_FFFC);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("t5_wrap_pc", pc, 32'hFFFF_FFFC);
      chk("t5_wrap_p4", pcplus4, 32'd0);
      step(0, 0, 0);
      chk("t5_wrapped", pc, 32'd0);
      // async reset in the middle of a stall
      repeat (2) step(0, 0, 0);
      repeat (2) step(1, 0, 0);
      #2 rst = 1'b1;
      #1 check_reset_vals();
      #1 rst = 1'b0;
      model_reset();
      repeat (3) step(0, 0, 0);
      chk("t6_refetch", pc, RESET_PC + 32'd4);
      // random traffic
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] t;
         case ($urandom_range(0, 3))
            0: t = 32'hFFFF_FFFC;
            1: t = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            default: t = $urandom;
         endcase
         step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, t);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
